// File: rtl/spi_ram_ctrl_pkg.sv
// Shared definitions for the SPI command path and RAM controller:
// opcode values and controller FSM state encodings.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command, response and RAM-side signals of the SPI RAM controller.
// The slave modport is the controller; master is the SPI slave plus RAM side.
interface spi_ram_ctrl_if #(
    parameter int ADDR_SIZE = 8
) ();
    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [7:0]           mem_rdata;
    logic                 err_clr;
    logic                 err;

    modport slave (
        input  rx_data, rx_valid, mem_rdata, err_clr,
        output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, err
    );

    modport master (
        output rx_data, rx_valid, mem_rdata, err_clr,
        input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, err
    );
endinterface

// File: rtl/spi_ram_ctrl_ram.sv
// Single-port synchronous RAM, MEM_DEPTH x 8, read data one cycle after re_i.
module spi_ram #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);
    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder driving a synchronous RAM: address/data writes with
// auto-increment and strobed reads returning data to the SPI slave.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);
    import spi_pkg::*;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    localparam addr_t LAST = addr_t'(MEM_DEPTH - 1);

    function automatic addr_t inc(addr_t a);
        return (a == LAST) ? '0 : a + addr_t'(1);
    endfunction

    state_e     state_q, state_d;
    addr_t      wr_addr_q, wr_addr_d;
    addr_t      rd_addr_q, rd_addr_d;
    logic       wr_ok_q, wr_ok_d;
    logic       rd_ok_q, rd_ok_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    addr_t      mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_re_q, mem_re_d;
    logic       err_q, err_d;
    logic       err_evt;

    opcode_e    op;
    logic [7:0] payload;

    assign op      = opcode_e'(bus.rx_data[9:8]);
    assign payload = bus.rx_data[7:0];

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_ok_d     = wr_ok_q;
        rd_ok_d     = rd_ok_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        err_evt     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RD_RESP: begin
                if (bus.rx_valid) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    unique case (op)
                        OP_WR_ADDR: begin
                            wr_addr_d = payload[ADDR_SIZE-1:0];
                            wr_ok_d   = 1'b1;
                        end
                        OP_WR_DATA: begin
                            if (wr_ok_q) begin
                                state_d     = ST_WRITE;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = wr_addr_q;
                                mem_wdata_d = payload;
                            end else begin
                                err_evt = 1'b1;
                            end
                        end
                        OP_RD_ADDR: begin
                            rd_addr_d = payload[ADDR_SIZE-1:0];
                            rd_ok_d   = 1'b1;
                        end
                        OP_RD_DATA: begin
                            if (rd_ok_q) begin
                                state_d    = ST_RD_REQ;
                                mem_re_d   = 1'b1;
                                mem_addr_d = rd_addr_q;
                            end else begin
                                err_evt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Busy states: commands are dropped, the operation runs to completion
            ST_WRITE: begin
                err_evt   = bus.rx_valid;
                state_d   = ST_IDLE;
                wr_addr_d = inc(wr_addr_q);
            end
            ST_RD_REQ: begin
                err_evt   = bus.rx_valid;
                state_d   = ST_RD_WAIT;
                rd_addr_d = inc(rd_addr_q);
            end
            ST_RD_WAIT: begin
                err_evt    = bus.rx_valid;
                state_d    = ST_RD_RESP;
                tx_data_d  = bus.mem_rdata;
                tx_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error wins over a simultaneous clear
        err_d = err_evt | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_ok_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_ok_q     <= wr_ok_d;
            rd_ok_q     <= rd_ok_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.err       = err_q;
endmodule
